// File: rtl/jt12_i2s_pkg.sv
// rtl/jt12_i2s_pkg.sv - shared constants and state encoding for the jt12 I2S transmitter
package jt12_i2s_pkg;

    localparam int PCM_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_t;

endpackage

// File: rtl/jt12_i2s_clkdiv.sv
// rtl/jt12_i2s_clkdiv.sv - sck generator: divide counter, registered sck and falling-edge strobe
module jt12_i2s_clkdiv #(
    parameter int SCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic fall
);

    localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [DW-1:0] div;
    logic          tc;

    assign tc   = (div == DW'(SCK_DIV - 1));
    // fall is asserted in the cycle whose closing edge drives sck low
    assign fall = en & tc & sck;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div <= '0;
            sck <= 1'b0;
        end else if (tc) begin
            div <= '0;
            sck <= ~sck;
        end else begin
            div <= div + DW'(1);
        end
    end

endmodule

// File: rtl/jt12_i2s_tx.sv
// rtl/jt12_i2s_tx.sv - I2S transmitter: holding regs, frame shifter, bit index and status pulses
module jt12_i2s_tx
    import jt12_i2s_pkg::*;
#(
    parameter int SCK_DIV = 2,
    parameter int SLOT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        sck,
    output logic        ws,
    output logic        sd,
    output logic        underrun,
    output logic        overrun
);

    localparam int FW = 2 * SLOT_W;
    localparam int BW = $clog2(FW);

    i2s_state_t          st;
    logic [PCM_W-1:0]    hl, hr;
    logic [PCM_W-1:0]    load_l, load_r;
    logic                pending;
    logic [FW-1:0]       sr;
    logic [FW-1:0]       fword;
    logic [BW-1:0]       b;
    logic [BW-1:0]       b_nxt;
    logic                run;
    logic                fall;
    logic                wrap;

    assign run = (st == ST_RUN);

    jt12_i2s_clkdiv #(.SCK_DIV(SCK_DIV)) u_clkdiv (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .sck  (sck),
        .fall (fall)
    );

    assign wrap   = fall && (b == BW'(FW - 1));
    assign b_nxt  = wrap ? '0 : b + BW'(1);
    // a strobe on the load cycle bypasses the holding regs
    assign load_l = sample ? left  : hl;
    assign load_r = sample ? right : hr;

    always_comb begin
        fword                    = '0;
        fword[FW-1     -: PCM_W] = load_l;
        fword[SLOT_W-1 -: PCM_W] = load_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            hl       <= '0;
            hr       <= '0;
            pending  <= 1'b0;
            sr       <= '0;
            b        <= '0;
            ws       <= 1'b0;
            sd       <= 1'b0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
            if (st == ST_IDLE) begin
                if (sample) begin
                    st      <= ST_RUN;
                    hl      <= load_l;
                    hr      <= load_r;
                    pending <= 1'b0;
                    sr      <= fword;
                    b       <= '0;
                    ws      <= 1'b0;
                    sd      <= 1'b0;
                end
            end else begin
                // sd lags the shifter by one bit, giving the I2S one-bit delay
                if (fall) begin
                    b  <= b_nxt;
                    ws <= (b_nxt >= BW'(SLOT_W));
                    sd <= sr[FW-1];
                    sr <= wrap ? fword : (sr << 1);
                end
                if (wrap) begin
                    hl       <= load_l;
                    hr       <= load_r;
                    pending  <= 1'b0;
                    underrun <= !sample && !pending;
                end else if (sample) begin
                    hl      <= left;
                    hr      <= right;
                    pending <= 1'b1;
                    overrun <= pending;
                end
            end
        end
    end

endmodule
